// File: rtl/uart_rx_if.sv
// Byte-stream side of the UART receiver: received byte with valid/ready handshake plus error pulses.
// The receiver drives the master modport and the consumer uses the slave modport.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised rx line into a single-entry output register,
// with one-cycle framing-error and overrun pulses.
module uart_rx #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 115200
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      rx,
   uart_rx_if.master out_if
);

   localparam int unsigned CyclesPerBit = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HalfBit      = CyclesPerBit / 2;
   localparam int unsigned CntW         = $clog2(CyclesPerBit);

   localparam logic [CntW-1:0] CntBitEnd  = CntW'(CyclesPerBit - 1);
   localparam logic [CntW-1:0] CntHalfEnd = CntW'(HalfBit - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            sync1_q, sync1_d;
   logic            rx_s_q, rx_s_d;
   logic            rx_prev_q, rx_prev_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
   logic            deliver;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CntW'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      sync1_d     = rx;
      rx_s_d      = sync1_q;
      rx_prev_d   = rx_s_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      deliver     = 1'b0;

      case (state_q)
         StIdle: begin
            // Edge detect, so a line stuck low never re-arms the receiver.
            if (rx_prev_q && !rx_s_q) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end
         StStart: begin
            if (cnt_q == CntHalfEnd) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               state_d   = rx_s_q ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == CntBitEnd) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (cnt_q == CntBitEnd) begin
               cnt_d   = '0;
               state_d = StIdle;
               if (rx_s_q) begin
                  deliver = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // A pending byte being consumed on the same edge frees the slot for the new one.
      if (deliver) begin
         if (!valid_q || out_if.rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && out_if.rx_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_prev_q   <= 1'b1;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         sync1_q     <= sync1_d;
         rx_s_q      <= rx_s_d;
         rx_prev_q   <= rx_prev_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_if.rx_data   = data_q;
   assign out_if.rx_valid  = valid_q;
   assign out_if.frame_err = frame_err_q;
   assign out_if.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters: bit-accurate line driver, negedge monitor
// and hand-computed expectations.
module tb_uart_rx;

   localparam int unsigned Cpb  = 434;
   localparam int unsigned Half = 217;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx    = 1'b1;

   uart_rx_if u_if ();

   uart_rx #(
      .CLK_FREQ  (50_000_000),
      .BAUD_RATE (115200)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx     (rx),
      .out_if (u_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: counters only ever grow; the stimulus takes snapshots and compares deltas.
   logic [7:0] got_mem [32];
   int got_n       = 0;
   int valid_cyc   = 0;
   int fe_cyc      = 0;
   int ov_cyc      = 0;
   int both_cyc    = 0;
   int rise_cyc    = 0;
   logic valid_prev = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (u_if.rx_valid && u_if.rx_ready && got_n < 32) begin
            got_mem[got_n] <= u_if.rx_data;
            got_n          <= got_n + 1;
         end
         if (u_if.rx_valid && !valid_prev) rise_cyc <= cyc;
         valid_prev <= u_if.rx_valid;
         valid_cyc  <= valid_cyc + int'(u_if.rx_valid);
         fe_cyc     <= fe_cyc + int'(u_if.frame_err);
         ov_cyc     <= ov_cyc + int'(u_if.overrun);
         both_cyc   <= both_cyc + int'(u_if.frame_err & u_if.overrun);
      end else begin
         valid_prev <= 1'b0;
      end
   end

   int n_checks = 0;
   int n_errors = 0;
   int rd       = 0;
   int start_cyc;
   int s_got, s_valid, s_fe, s_ov;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      s_got   = got_n;
      s_valid = valid_cyc;
      s_fe    = fe_cyc;
      s_ov    = ov_cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; leaves the line on the last driven bit, aligned to posedge+1.
   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         if (i == 0) start_cyc = cyc + 1;
         idle(Cpb);
      end
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp);
      check_eq(tag, {24'h0, got_mem[rd]}, {24'h0, exp});
      rd++;
   endtask

   initial begin
      logic [9:0] fr;
      u_if.rx_ready = 1'b0;
      #23;
      check_eq("reset_rx_data",   {24'h0, u_if.rx_data}, 32'h00);
      check_eq("reset_rx_valid",  {31'h0, u_if.rx_valid}, 32'h0);
      check_eq("reset_frame_err", {31'h0, u_if.frame_err}, 32'h0);
      check_eq("reset_overrun",   {31'h0, u_if.overrun}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(20);

      // Single byte with latency measurement.
      u_if.rx_ready = 1'b1;
      snap();
      send_byte(8'h55, 1'b1);
      rx = 1'b1;
      idle(10);
      check_eq("t1_count",   got_n - s_got, 1);
      expect_byte("t1_byte", 8'h55);
      check_eq("t1_latency", rise_cyc - start_cyc, Half + 9 * Cpb + 2);
      check_eq("t1_valid_cycles", valid_cyc - s_valid, 1);
      check_eq("t1_flags", (fe_cyc - s_fe) + (ov_cyc - s_ov), 0);

      // Back-to-back frames with no idle bits between them.
      snap();
      send_byte(8'hA3, 1'b1);
      send_byte(8'h0F, 1'b1);
      idle(10);
      check_eq("t2_count", got_n - s_got, 2);
      expect_byte("t2_byte0", 8'hA3);
      expect_byte("t2_byte1", 8'h0F);
      check_eq("t2_flags", (fe_cyc - s_fe) + (ov_cyc - s_ov), 0);

      // Short low glitch is rejected at the start-bit midpoint.
      snap();
      rx = 1'b0;
      idle(100);
      rx = 1'b1;
      idle(600);
      check_eq("t3_glitch_valid", valid_cyc - s_valid, 0);
      check_eq("t3_glitch_flags", (fe_cyc - s_fe) + (ov_cyc - s_ov), 0);
      send_byte(8'h81, 1'b1);
      idle(10);
      check_eq("t3_count", got_n - s_got, 1);
      expect_byte("t3_byte", 8'h81);

      // Stop bit low: one-cycle frame_err, byte discarded.
      snap();
      send_byte(8'hFF, 1'b0);
      rx = 1'b1;
      idle(50);
      check_eq("t4_frame_err_cycles", fe_cyc - s_fe, 1);
      check_eq("t4_no_valid", valid_cyc - s_valid, 0);
      check_eq("t4_no_overrun", ov_cyc - s_ov, 0);
      send_byte(8'h12, 1'b1);
      idle(10);
      check_eq("t4_count", got_n - s_got, 1);
      expect_byte("t4_byte", 8'h12);

      // Overrun: first byte held, second dropped with a one-cycle pulse.
      u_if.rx_ready = 1'b0;
      snap();
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      idle(10);
      check_eq("t5_valid_held", {31'h0, u_if.rx_valid}, 32'h1);
      check_eq("t5_data_held",  {24'h0, u_if.rx_data}, 32'h11);
      check_eq("t5_overrun_cycles", ov_cyc - s_ov, 1);
      check_eq("t5_no_frame_err", fe_cyc - s_fe, 0);
      u_if.rx_ready = 1'b1;
      idle(3);
      check_eq("t5_consumed_valid", {31'h0, u_if.rx_valid}, 32'h0);
      check_eq("t5_data_after",     {24'h0, u_if.rx_data}, 32'h11);
      check_eq("t5_count", got_n - s_got, 1);
      expect_byte("t5_byte", 8'h11);

      // Asynchronous reset in data bit 4 while a byte is pending.
      u_if.rx_ready = 1'b0;
      send_byte(8'h5A, 1'b1);
      idle(10);
      check_eq("t6_pending_valid", {31'h0, u_if.rx_valid}, 32'h1);
      check_eq("t6_pending_data",  {24'h0, u_if.rx_data}, 32'h5A);
      fr = {1'b1, 8'h3C, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx = fr[i];
         idle(Cpb);
      end
      rx = fr[5];
      idle(Cpb / 2);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_valid",     {31'h0, u_if.rx_valid}, 32'h0);
      check_eq("t6_rst_data",      {24'h0, u_if.rx_data}, 32'h00);
      check_eq("t6_rst_frame_err", {31'h0, u_if.frame_err}, 32'h0);
      check_eq("t6_rst_overrun",   {31'h0, u_if.overrun}, 32'h0);
      rx = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(20);
      u_if.rx_ready = 1'b1;
      snap();
      send_byte(8'h3C, 1'b1);
      idle(10);
      check_eq("t6_count", got_n - s_got, 1);
      expect_byte("t6_byte", 8'h3C);
      check_eq("t6_flags", (fe_cyc - s_fe) + (ov_cyc - s_ov), 0);

      check_eq("never_both_flags", both_cyc, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
